// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- stall/flush sequencer for the 5-stage pipeline.
// Drives enable/flush controls of the PC, IF_ID, ID_EX and EX_MEM registers:
// freezes the pipe during multi-cycle data-memory accesses, inserts one bubble
// on a load-use hazard and squashes younger instructions on a taken branch.
// Keeps saturating stall / flush statistics counters.
// Optional build macro: MEM_TIMEOUT_EN -- aborts a memory wait after TIMEOUT
// MEM_WAIT cycles and raises the sticky Mem_Err flag.
module pipe_hazard_ctrl #(
   parameter int ZERO_REG_HARDWIRED = 1,
   parameter int CNT_W              = 16,
   parameter int TIMEOUT            = 255
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [3:0]       IF_ID_RS1,
   input  logic [3:0]       IF_ID_RS2,
   input  logic             IF_ID_Use1,
   input  logic             IF_ID_Use2,
   input  logic             ID_EX_MR,
   input  logic [3:0]       ID_EX_WN,
   input  logic             EX_MEM_MR,
   input  logic             EX_MEM_MW,
   input  logic             Mem_Ready,
   input  logic             Branch_Taken,
   output logic             PC_En,
   output logic             IF_ID_En,
   output logic             ID_EX_En,
   output logic             EX_MEM_En,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             Mem_Req,
   output logic             Mem_Err,
   output logic [CNT_W-1:0] Stall_Cycles,
   output logic [CNT_W-1:0] Flush_Count
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             acc_s;
   logic             ready_s;
   logic             timeout_s;
   logic             mem_stall_s;
   logic             wn_ok_s;
   logic             rs1_hit_s;
   logic             rs2_hit_s;
   logic             lu_s;
   logic             pc_en_s;
   logic             if_id_en_s;
   logic             id_ex_en_s;
   logic             ex_mem_en_s;
   logic             if_id_flush_s;
   logic             id_ex_flush_s;
   logic             mem_req_s;
   logic             mem_err_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   // Saturating increment: an all-ones counter holds its value.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   assign acc_s     = EX_MEM_MR | EX_MEM_MW;
   // A timeout abort behaves exactly like a ready memory for the sequencer.
   assign ready_s   = Mem_Ready | timeout_s;

   // A load writing r0 is harmless when r0 is hardwired to zero.
   assign wn_ok_s   = (ZERO_REG_HARDWIRED == 0) || (ID_EX_WN != 4'd0);
   assign rs1_hit_s = IF_ID_Use1 && (IF_ID_RS1 == ID_EX_WN);
   assign rs2_hit_s = IF_ID_Use2 && (IF_ID_RS2 == ID_EX_WN);
   assign lu_s      = ID_EX_MR && wn_ok_s && (rs1_hit_s || rs2_hit_s);

`ifdef MEM_TIMEOUT_EN
   localparam int                WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

   logic [WAIT_W-1:0] wait_cnt_r;
   logic              mem_err_r;

   assign timeout_s = (state_r == MEM_WAIT) && !Mem_Ready && (wait_cnt_r == TIMEOUT_C);
   assign mem_err_s = mem_err_r;

   // Wait counter: held at zero in RUN so it starts cleared on entering MEM_WAIT.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wait_cnt_r <= {WAIT_W{1'b0}};
      end else if (state_r == RUN) begin
         wait_cnt_r <= {WAIT_W{1'b0}};
      end else if (!ready_s) begin
         wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Sticky error flag: set by an aborted access, cleared only by reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         mem_err_r <= 1'b0;
      end else if (timeout_s) begin
         mem_err_r <= 1'b1;
      end else begin
         mem_err_r <= mem_err_r;
      end
   end
`else
   logic unused_timeout_s;

   assign unused_timeout_s = (TIMEOUT != 0);
   assign timeout_s        = 1'b0;
   assign mem_err_s        = 1'b0;
`endif

   // Memory handshake: request, stall condition and next FSM state.
   always_comb begin
      mem_req_s   = 1'b0;
      mem_stall_s = 1'b0;
      state_nxt_s = state_r;
      case (state_r)
         RUN: begin
            mem_req_s = acc_s;
            if (acc_s && !Mem_Ready) begin
               mem_stall_s = 1'b1;
               state_nxt_s = MEM_WAIT;
            end else begin
               mem_stall_s = 1'b0;
               state_nxt_s = RUN;
            end
         end
         MEM_WAIT: begin
            mem_req_s = 1'b1;
            if (ready_s) begin
               mem_stall_s = 1'b0;
               state_nxt_s = RUN;
            end else begin
               mem_stall_s = 1'b1;
               state_nxt_s = MEM_WAIT;
            end
         end
         default: begin
            mem_req_s   = 1'b0;
            mem_stall_s = 1'b0;
            state_nxt_s = RUN;
         end
      endcase
   end

   // Pipeline control priority: memory stall, then branch squash, then load-use bubble.
   always_comb begin
      pc_en_s       = 1'b1;
      if_id_en_s    = 1'b1;
      id_ex_en_s    = 1'b1;
      ex_mem_en_s   = 1'b1;
      if_id_flush_s = 1'b0;
      id_ex_flush_s = 1'b0;
      if (mem_stall_s) begin
         pc_en_s       = 1'b0;
         if_id_en_s    = 1'b0;
         id_ex_en_s    = 1'b0;
         ex_mem_en_s   = 1'b0;
         if_id_flush_s = 1'b0;
         id_ex_flush_s = 1'b0;
      end else if (Branch_Taken) begin
         if_id_flush_s = 1'b1;
         id_ex_flush_s = 1'b1;
      end else if (lu_s) begin
         pc_en_s       = 1'b0;
         if_id_en_s    = 1'b0;
         id_ex_flush_s = 1'b1;
      end else begin
         pc_en_s       = 1'b1;
         if_id_flush_s = 1'b0;
      end
   end

   // FSM state and statistics counters.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r     <= RUN;
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         stall_cnt_r <= pc_en_s       ? stall_cnt_r : sat_inc(stall_cnt_r);
         flush_cnt_r <= if_id_flush_s ? sat_inc(flush_cnt_r) : flush_cnt_r;
      end
   end

   // Every control output is forced low while reset is asserted.
   assign PC_En        = Rst_n & pc_en_s;
   assign IF_ID_En     = Rst_n & if_id_en_s;
   assign ID_EX_En     = Rst_n & id_ex_en_s;
   assign EX_MEM_En    = Rst_n & ex_mem_en_s;
   assign IF_ID_Flush  = Rst_n & if_id_flush_s;
   assign ID_EX_Flush  = Rst_n & id_ex_flush_s;
   assign Mem_Req      = Rst_n & mem_req_s;
   assign Mem_Err      = Rst_n & mem_err_s;
   assign Stall_Cycles = stall_cnt_r;
   assign Flush_Count  = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (CNT_W=8 so saturation is reachable,
// TIMEOUT=4 for the optional MEM_TIMEOUT_EN build).
module tb_pipe_hazard_ctrl;

   localparam int CW = 8;

   logic          Clk;
   logic          Rst_n;
   logic [3:0]    IF_ID_RS1;
   logic [3:0]    IF_ID_RS2;
   logic          IF_ID_Use1;
   logic          IF_ID_Use2;
   logic          ID_EX_MR;
   logic [3:0]    ID_EX_WN;
   logic          EX_MEM_MR;
   logic          EX_MEM_MW;
   logic          Mem_Ready;
   logic          Branch_Taken;
   logic          PC_En;
   logic          IF_ID_En;
   logic          ID_EX_En;
   logic          EX_MEM_En;
   logic          IF_ID_Flush;
   logic          ID_EX_Flush;
   logic          Mem_Req;
   logic          Mem_Err;
   logic [CW-1:0] Stall_Cycles;
   logic [CW-1:0] Flush_Count;

   logic [6:0]    ctrl_s;
   int            n_cmp;
   int            n_err;

   pipe_hazard_ctrl #(
      .ZERO_REG_HARDWIRED(1),
      .CNT_W(CW),
      .TIMEOUT(4)
   ) dut (
      .Clk(Clk),
      .Rst_n(Rst_n),
      .IF_ID_RS1(IF_ID_RS1),
      .IF_ID_RS2(IF_ID_RS2),
      .IF_ID_Use1(IF_ID_Use1),
      .IF_ID_Use2(IF_ID_Use2),
      .ID_EX_MR(ID_EX_MR),
      .ID_EX_WN(ID_EX_WN),
      .EX_MEM_MR(EX_MEM_MR),
      .EX_MEM_MW(EX_MEM_MW),
      .Mem_Ready(Mem_Ready),
      .Branch_Taken(Branch_Taken),
      .PC_En(PC_En),
      .IF_ID_En(IF_ID_En),
      .ID_EX_En(ID_EX_En),
      .EX_MEM_En(EX_MEM_En),
      .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Flush(ID_EX_Flush),
      .Mem_Req(Mem_Req),
      .Mem_Err(Mem_Err),
      .Stall_Cycles(Stall_Cycles),
      .Flush_Count(Flush_Count)
   );

   // {PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, IF_ID_Flush, ID_EX_Flush, Mem_Req}
   assign ctrl_s = {PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, IF_ID_Flush, ID_EX_Flush, Mem_Req};

   // Free-running clock, period 10.
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctrl(input string tag, input logic [6:0] exp);
      chk(tag, {25'd0, ctrl_s}, {25'd0, exp});
   endtask

   task automatic chk_cnt(input string tag, input logic [CW-1:0] st, input logic [CW-1:0] fl);
      chk({tag, "_stall"}, {24'd0, Stall_Cycles}, {24'd0, st});
      chk({tag, "_flush"}, {24'd0, Flush_Count}, {24'd0, fl});
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      IF_ID_RS1    = 4'd0;
      IF_ID_RS2    = 4'd0;
      IF_ID_Use1   = 1'b0;
      IF_ID_Use2   = 1'b0;
      ID_EX_MR     = 1'b0;
      ID_EX_WN     = 4'd0;
      EX_MEM_MR    = 1'b0;
      EX_MEM_MW    = 1'b0;
      Mem_Ready    = 1'b0;
      Branch_Taken = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      idle();
      Rst_n = 1'b0;
      #2;
      chk_ctrl("reset_ctrl", 7'b0000000);
      chk("reset_err", {31'd0, Mem_Err}, 32'd0);
      chk_cnt("reset", 8'd0, 8'd0);

      @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      chk_ctrl("post_reset_ctrl", 7'b1111000);
      chk_cnt("post_reset", 8'd0, 8'd0);

      // Zero-wait load: request, no stall, stays in RUN.
      cyc();
      EX_MEM_MR = 1'b1;
      Mem_Ready = 1'b1;
      #1;
      chk_ctrl("zw_load", 7'b1111001);
      cyc();
      idle();
      #1;
      chk_ctrl("zw_after", 7'b1111000);
      chk_cnt("zw", 8'd0, 8'd0);

      // Mem_Ready with no access is ignored.
      Mem_Ready = 1'b1;
      #1;
      chk_ctrl("ready_no_acc", 7'b1111000);

      // Three-wait store.
      cyc();
      idle();
      EX_MEM_MW = 1'b1;
      #1;
      chk_ctrl("st_w1", 7'b0000001);
      cyc();
      #1;
      chk_ctrl("st_w2", 7'b0000001);
      cyc();
      #1;
      chk_ctrl("st_w3", 7'b0000001);
      cyc();
      Mem_Ready = 1'b1;
      #1;
      chk_ctrl("st_ready", 7'b1111001);
      cyc();
      idle();
      #1;
      chk_ctrl("st_after", 7'b1111000);
      chk_cnt("st", 8'd3, 8'd0);

      // Load-use via RS2.
      ID_EX_MR   = 1'b1;
      ID_EX_WN   = 4'd5;
      IF_ID_RS1  = 4'd3;
      IF_ID_Use1 = 1'b1;
      IF_ID_RS2  = 4'd5;
      IF_ID_Use2 = 1'b1;
      #1;
      chk_ctrl("lu_rs2", 7'b0011010);
      cyc();
      ID_EX_MR = 1'b0;
      #1;
      chk_ctrl("lu_clear", 7'b1111000);
      chk_cnt("lu", 8'd4, 8'd0);

      // Destination r0 never hazards.
      ID_EX_MR   = 1'b1;
      ID_EX_WN   = 4'd0;
      IF_ID_RS1  = 4'd0;
      IF_ID_Use1 = 1'b1;
      IF_ID_RS2  = 4'd0;
      IF_ID_Use2 = 1'b1;
      #1;
      chk_ctrl("lu_r0", 7'b1111000);

      // Matching register but its use flag is low.
      ID_EX_WN   = 4'd9;
      IF_ID_RS1  = 4'd9;
      IF_ID_Use1 = 1'b0;
      IF_ID_RS2  = 4'd9;
      IF_ID_Use2 = 1'b0;
      #1;
      chk_ctrl("lu_nouse", 7'b1111000);

      // Load-use via RS1.
      ID_EX_WN   = 4'd7;
      IF_ID_RS1  = 4'd7;
      IF_ID_Use1 = 1'b1;
      #1;
      chk_ctrl("lu_rs1", 7'b0011010);
      cyc();
      idle();
      #1;
      chk_cnt("lu_rs1", 8'd5, 8'd0);

      // Branch together with a load-use hazard: branch wins.
      ID_EX_MR     = 1'b1;
      ID_EX_WN     = 4'd5;
      IF_ID_RS2    = 4'd5;
      IF_ID_Use2   = 1'b1;
      Branch_Taken = 1'b1;
      #1;
      chk_ctrl("br_lu", 7'b1111110);
      cyc();
      idle();
      #1;
      chk_cnt("br_lu", 8'd5, 8'd1);

      // Branch during a memory wait: held until the ready cycle.
      EX_MEM_MR    = 1'b1;
      Branch_Taken = 1'b1;
      #1;
      chk_ctrl("br_mw1", 7'b0000001);
      cyc();
      #1;
      chk_ctrl("br_mw2", 7'b0000001);
      cyc();
      Mem_Ready = 1'b1;
      #1;
      chk_ctrl("br_mw_ready", 7'b1111111);
      cyc();
      idle();
      #1;
      chk_cnt("br_mw", 8'd7, 8'd2);

      // Reset in the middle of MEM_WAIT.
      EX_MEM_MW = 1'b1;
      #1;
      chk_ctrl("rst_mw_run", 7'b0000001);
      cyc();
      #1;
      chk_ctrl("rst_mw_wait", 7'b0000001);
      Rst_n = 1'b0;
      #1;
      chk_ctrl("rst_mw_ctrl", 7'b0000000);
      chk("rst_mw_err", {31'd0, Mem_Err}, 32'd0);
      chk_cnt("rst_mw", 8'd0, 8'd0);
      idle();
      @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      chk_ctrl("rst_mw_release", 7'b1111000);
      cyc();
      #1;
      chk_ctrl("rst_mw_idle", 7'b1111000);
      chk_cnt("rst_mw_idle", 8'd0, 8'd0);

`ifdef MEM_TIMEOUT_EN
      // Memory never ready: 1 RUN stall + 4 MEM_WAIT stalls, then abort.
      EX_MEM_MR = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk_ctrl("to_stall", 7'b0000001);
         cyc();
      end
      #1;
      chk_ctrl("to_abort", 7'b1111001);
      cyc();
      idle();
      #1;
      chk("to_err", {31'd0, Mem_Err}, 32'd1);
      chk_cnt("to", 8'd5, 8'd0);
      EX_MEM_MW = 1'b1;
      Mem_Ready = 1'b1;
      cyc();
      idle();
      #1;
      chk("to_err_sticky", {31'd0, Mem_Err}, 32'd1);
      chk_ctrl("to_idle", 7'b1111000);
`else
      // Without timeout the stall persists; the stall counter saturates at 255.
      EX_MEM_MR = 1'b1;
      for (int i = 0; i < 300; i++) begin
         #1;
         chk_ctrl("nto_stall", 7'b0000001);
         cyc();
      end
      #1;
      chk("nto_err", {31'd0, Mem_Err}, 32'd0);
      chk_cnt("nto_sat", 8'd255, 8'd0);
      Mem_Ready = 1'b1;
      #1;
      chk_ctrl("nto_ready", 7'b1111001);
      cyc();
      idle();
      #1;
      chk_ctrl("nto_idle", 7'b1111000);
      chk_cnt("nto_after", 8'd255, 8'd0);
`endif

      // Flush counter saturation.
      Branch_Taken = 1'b1;
      for (int i = 0; i < 260; i++) begin
         cyc();
      end
      idle();
      #1;
      chk("flush_sat", {24'd0, Flush_Count}, 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush controls of the PC, IF_ID, ID_EX and EX_MEM pipeline registers.
- Freezes the pipeline while the data memory completes a multi-cycle access issued from the EX_MEM stage.
- Inserts a one-cycle bubble on load-use hazards and squashes younger instructions on a taken branch.
- Keeps saturating stall and flush statistics counters.

Parameters:
- ZERO_REG_HARDWIRED, 1, when 1 a write target of register 0 never causes a load-use hazard.
- CNT_W, 16, width of the statistics counters.
- TIMEOUT, 255, maximum memory-wait cycles; used only with MEM_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- IF_ID_RS1  in  4  source register 1 of the instruction in ID.
- IF_ID_RS2  in  4  source register 2 of the instruction in ID.
- IF_ID_Use1  in  1  ID instruction reads RS1.
- IF_ID_Use2  in  1  ID instruction reads RS2.
- ID_EX_MR  in  1  instruction in EX is a load.
- ID_EX_WN  in  4  destination register of the instruction in EX.
- EX_MEM_MR  in  1  MEM-stage load.
- EX_MEM_MW  in  1  MEM-stage store.
- Mem_Ready  in  1  data memory completes the current access this cycle.
- Branch_Taken  in  1  taken branch resolved in EX this cycle.
- PC_En  out  1  PC update enable.
- IF_ID_En  out  1  IF_ID register load enable.
- ID_EX_En  out  1  ID_EX register load enable.
- EX_MEM_En  out  1  EX_MEM register load enable.
- IF_ID_Flush  out  1  IF_ID loads a NOP.
- ID_EX_Flush  out  1  ID_EX loads a bubble (all control bits 0).
- Mem_Req  out  1  data memory access request.
- Mem_Err  out  1  sticky memory-timeout flag.
- Stall_Cycles  out  CNT_W  saturating count of cycles with PC_En=0.
- Flush_Count  out  CNT_W  saturating count of cycles with IF_ID_Flush=1.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - state=RUN; counters=0; Mem_Err=0.
  - All outputs are forced to 0 while Rst_n is low, including all enables.
  - Reset during MEM_WAIT abandons the access; Mem_Req drops immediately.
- FSM states: RUN, MEM_WAIT. All control outputs are combinational (Mealy) from state and inputs; state and counters are registered.
- acc = EX_MEM_MR | EX_MEM_MW.
- Mem_Req = acc in RUN; Mem_Req = 1 in MEM_WAIT.
- mem_stall = (RUN & acc & ~Mem_Ready) | (MEM_WAIT & ~Mem_Ready).
- RUN -> MEM_WAIT when acc & ~Mem_Ready.
- MEM_WAIT -> RUN on Mem_Ready.
- A zero-wait access (acc & Mem_Ready in RUN) causes no stall.
- Mem_Ready while acc=0 in RUN is ignored.
- lu = ID_EX_MR & (~ZERO_REG_HARDWIRED | ID_EX_WN!=0) & ((IF_ID_Use1 & RS1==ID_EX_WN) | (IF_ID_Use2 & RS2==ID_EX_WN)).
- Priority 1, mem_stall: all four enables 0, both flushes 0; Branch_Taken and lu are ignored that cycle and re-evaluated once the stall releases (the EX inputs are held).
- Priority 2, Branch_Taken: all enables 1, IF_ID_Flush=1, ID_EX_Flush=1; lu is ignored.
- Priority 3, lu: PC_En=0, IF_ID_En=0, ID_EX_En=1 with ID_EX_Flush=1, EX_MEM_En=1.
  - Exactly one bubble per hazard; the load advances to MEM next cycle so lu clears.
- Otherwise: all enables 1, flushes 0.
- Stall_Cycles increments on every cycle with PC_En=0 (mem_stall or lu) and saturates at all-ones.
- Flush_Count increments on every cycle with IF_ID_Flush=1 and saturates at all-ones.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering MEM_WAIT and increments each MEM_WAIT cycle.
  - When it equals TIMEOUT with Mem_Ready still 0, the access is aborted that cycle: treated as if Mem_Ready=1 (enables 1, return to RUN), and Mem_Err is set.
  - Mem_Err stays set until reset.
- Not defined: no wait counter; MEM_WAIT persists until Mem_Ready; Mem_Err is tied to 0.

Test Plan:
- Reset: assert Rst_n=0 mid-MEM_WAIT -> all outputs 0 immediately; after release with no activity -> all enables 1, counters 0.
- Zero-wait load: EX_MEM_MR=1, Mem_Ready=1 -> Mem_Req=1, no stall, state stays RUN.
- 3-wait store: EX_MEM_MW=1, Mem_Ready low for 3 cycles then high -> enables 0 for exactly 3 cycles, 1 on the ready cycle; Stall_Cycles=3.
- Load-use: ID_EX_MR=1, ID_EX_WN=5, RS2=5, Use2=1 -> one cycle of PC_En=0, IF_ID_En=0, ID_EX_Flush=1; the same with ID_EX_WN=0 and ZERO_REG_HARDWIRED=1 -> no stall.
- Simultaneous events:
  - Branch_Taken with lu -> both flushes 1, PC_En=1, Flush_Count+1.
  - Branch_Taken during a memory wait -> no flush until Mem_Ready; the flush occurs on the ready cycle.
- MEM_TIMEOUT_EN, TIMEOUT=4, Mem_Ready held 0 -> release after 4 MEM_WAIT cycles; Mem_Err=1 and stays 1 after a later normal access; without the macro -> stall persists (check for 300 cycles) and Mem_Err=0.
